// File: rtl/ou_pkg.sv
// Shared Output Unit types: BCD digit width, converter state encoding.
package ou_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic {IDLE, SHIFT} bcd_state_t;

  typedef logic [BCD_W-1:0] bcd_digit_t;

endpackage

// File: rtl/bcd_seq_converter_add3.sv
// Shift-and-add-3 correction for one BCD digit: values >= 5 get +3 before the shift.
module bcd_seq_converter_add3
  import ou_pkg::*;
(
  input  bcd_digit_t d,
  output bcd_digit_t q
);

  assign q = (d >= bcd_digit_t'(5)) ? bcd_digit_t'(d + bcd_digit_t'(3)) : d;

endmodule

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter, one shift per clock, with sign flag and
// leading-zero mask for the seven-segment driver.
module bcd_seq_converter
  import ou_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    is_signed,
  input  logic [WIDTH-1:0]        bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] bcd_out,
  output logic                    sign_out,
  output logic [DIGITS-1:0]       lz_mask
);

  localparam int unsigned SW = BCD_W * DIGITS;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  if (10**DIGITS <= 2**WIDTH) begin : g_bad_digits
    $error("bcd_seq_converter: DIGITS too small to hold 2**WIDTH");
  end

  bcd_state_t        state;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     scratch;
  logic [WIDTH-1:0]  mag;
  logic              neg;

  logic [SW-1:0]     corr;
  logic [SW-1:0]     scratch_nxt;
  logic [DIGITS-1:0] lz_nxt;

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
    bcd_seq_converter_add3 u_add3 (
      .d (scratch[g*BCD_W +: BCD_W]),
      .q (corr[g*BCD_W +: BCD_W])
    );
  end

  assign scratch_nxt = {corr[SW-2:0], mag[WIDTH-1]};

  // Leading-zero mask scans from the top digit down; the units digit is always shown.
  always_comb begin
    logic all_zero;
    lz_nxt   = '0;
    all_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i > 0; i--) begin
      all_zero  = all_zero & (scratch_nxt[i*BCD_W +: BCD_W] == '0);
      lz_nxt[i] = all_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      scratch  <= '0;
      mag      <= '0;
      neg      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd_out  <= '0;
      sign_out <= 1'b0;
      lz_mask  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mag     <= (is_signed && bin_in[WIDTH-1]) ? WIDTH'(-bin_in) : bin_in;
            neg     <= is_signed && bin_in[WIDTH-1];
            scratch <= '0;
            cnt     <= CW'(WIDTH - 1);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          mag     <= {mag[WIDTH-2:0], 1'b0};
          cnt     <= cnt - CW'(1);
          if (cnt == '0) begin
            bcd_out  <= scratch_nxt;
            sign_out <= neg && (scratch_nxt != '0);
            lz_mask  <= lz_nxt;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Directed bench for bcd_seq_converter: vector table plus back-to-back and reset-abort sequences.
module tb_bcd_seq_converter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [19:0] bcd_out;
  logic        sign_out;
  logic [4:0]  lz_mask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .sign_out  (sign_out),
    .lz_mask   (lz_mask)
  );

  typedef struct {
    logic        sg;
    logic [15:0] v;
    logic [19:0] bcd;
    logic        sgn;
    logic [4:0]  lz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Launch one conversion and return the cycle count from the accepting edge to done.
  task automatic run(input logic sg, input logic [15:0] v, output int lat);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sg;
    bin_in    = v;
    @(posedge clk); #1;
    check("busy_on_accept", 32'(busy), 32'd1);
    @(negedge clk);
    start = 1'b0;
    lat = 99;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int ndone;
    int t_first;
    int t_second;
    logic [19:0] bcd_first;
    logic [19:0] bcd_second;

    vecs[0]  = '{1'b0, 16'd0,     20'h00000, 1'b0, 5'b11110};
    vecs[1]  = '{1'b0, 16'd65535, 20'h65535, 1'b0, 5'b00000};
    vecs[2]  = '{1'b1, 16'hFF85,  20'h00123, 1'b1, 5'b11000};
    vecs[3]  = '{1'b1, 16'h8000,  20'h32768, 1'b1, 5'b00000};
    vecs[4]  = '{1'b0, 16'h8000,  20'h32768, 1'b0, 5'b00000};
    vecs[5]  = '{1'b1, 16'hFFFF,  20'h00001, 1'b1, 5'b11110};
    vecs[6]  = '{1'b1, 16'h7FFF,  20'h32767, 1'b0, 5'b00000};
    vecs[7]  = '{1'b0, 16'd42,    20'h00042, 1'b0, 5'b11100};
    vecs[8]  = '{1'b0, 16'd9,     20'h00009, 1'b0, 5'b11110};
    vecs[9]  = '{1'b0, 16'd1000,  20'h01000, 1'b0, 5'b10000};
    vecs[10] = '{1'b1, 16'hFC18,  20'h01000, 1'b1, 5'b10000};
    vecs[11] = '{1'b0, 16'd10,    20'h00010, 1'b0, 5'b11100};
    vecs[12] = '{1'b1, 16'd0,     20'h00000, 1'b0, 5'b11110};

    rst_n     = 1'b0;
    start     = 1'b0;
    is_signed = 1'b0;
    bin_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd_out), 32'd0);
    check("rst_sign", 32'(sign_out), 32'd0);
    check("rst_lz",   32'(lz_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run(vecs[i].sg, vecs[i].v, lat);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd16);
      check($sformatf("v%0d_bcd", i),  32'(bcd_out), 32'(vecs[i].bcd));
      check($sformatf("v%0d_sign", i), 32'(sign_out), 32'(vecs[i].sgn));
      check($sformatf("v%0d_lz", i),   32'(lz_mask), 32'(vecs[i].lz));
      check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
      check($sformatf("v%0d_hold", i), 32'(bcd_out), 32'(vecs[i].bcd));
    end

    // start held high: 42 then 7 back-to-back, mid-busy start is ignored.
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    bin_in    = 16'd42;
    @(posedge clk);
    @(negedge clk);
    bin_in     = 16'd7;
    ndone      = 0;
    t_first    = 0;
    t_second   = 0;
    bcd_first  = '0;
    bcd_second = '0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (ndone == 1) begin t_first = n; bcd_first = bcd_out; end
        if (ndone == 2) begin t_second = n; bcd_second = bcd_out; end
      end
    end
    check("b2b_done_count", 32'(ndone), 32'd2);
    check("b2b_first_time", 32'(t_first), 32'd16);
    check("b2b_first_bcd", 32'(bcd_first), 32'h00042);
    check("b2b_second_time", 32'(t_second), 32'd33);
    check("b2b_second_bcd", 32'(bcd_second), 32'h00007);
    @(negedge clk);
    start = 1'b0;
    lat = 99;
    for (int n = 1; n <= 30; n++) begin
      @(posedge clk); #1;
      if (!busy) begin
        lat = n;
        break;
      end
    end
    check("b2b_drain", 32'(lat <= 20), 32'd1);
    check("b2b_third_bcd", 32'(bcd_out), 32'h00007);

    // Reset eight cycles into a conversion aborts it with no done.
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b1;
    bin_in    = 16'hFF85;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bcd",  32'(bcd_out), 32'd0);
    check("abort_sign", 32'(sign_out), 32'd0);
    check("abort_lz",   32'(lz_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    run(1'b0, 16'h3039, lat);
    check("post_rst_latency", 32'(lat), 32'd16);
    check("post_rst_bcd",  32'(bcd_out), 32'h12345);
    check("post_rst_sign", 32'(sign_out), 32'd0);
    check("post_rst_lz",   32'(lz_mask), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
